// File: rtl/sram_bank_bridge_pkg.sv
// Shared types and limits for the crossbar-slave to single-port SRAM bridge.
package sram_bridge_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } pwr_state_t;

    localparam int MAX_READ_LATENCY = 4;
    localparam int MAX_WAKE_CYCLES  = 15;
    localparam int WAKE_CNT_WIDTH   = 4;

    typedef struct packed {
        logic valid;
        logic is_read;
    } resp_token_t;

    // Idle counter must hold 0..IDLE_CYCLES; keep at least one bit when sleep is disabled.
    function automatic int idle_cnt_width(input int idle_cycles);
        return (idle_cycles < 1) ? 1 : $clog2(idle_cycles + 1);
    endfunction

endpackage

// File: rtl/sram_bank_bridge_if.sv
// Interconnect slave-side req/gnt/rvalid bus as seen by one SRAM bank bridge.
interface sram_bank_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                      slave_data_req_i;
    logic [ADDR_WIDTH-1:0]     slave_data_addr_i;
    logic                      slave_data_we_i;
    logic [DATA_WIDTH/8-1:0]   slave_data_be_i;
    logic [DATA_WIDTH-1:0]     slave_data_wdata_i;
    logic                      slave_data_gnt_o;
    logic                      slave_data_rvalid_o;
    logic [DATA_WIDTH-1:0]     slave_data_rdata_o;

    modport master (
        output slave_data_req_i, slave_data_addr_i, slave_data_we_i,
               slave_data_be_i, slave_data_wdata_i,
        input  slave_data_gnt_o, slave_data_rvalid_o, slave_data_rdata_o
    );

    modport slave (
        input  slave_data_req_i, slave_data_addr_i, slave_data_we_i,
               slave_data_be_i, slave_data_wdata_i,
        output slave_data_gnt_o, slave_data_rvalid_o, slave_data_rdata_o
    );
endinterface

// File: rtl/sram_bank_bridge_resp_pipe.sv
// Fixed-depth response token shift register; head appears DEPTH cycles after push.
module sram_resp_pipe
    import sram_bridge_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  resp_token_t push_i,
    output resp_token_t head_o,
    output logic        empty_o
);
    resp_token_t [DEPTH-1:0] stage_q;
    resp_token_t [DEPTH-1:0] stage_d;
    logic        [DEPTH-1:0] valid_vec;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = push_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Reset flushes every in-flight token so no stale response escapes after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        assign valid_vec[gi] = stage_q[gi].valid;
    end

    assign head_o  = stage_q[DEPTH-1];
    assign empty_o = ~|valid_vec;

endmodule

// File: rtl/sram_bank_bridge.sv
// Crossbar slave port to single-port SRAM macro bridge with idle sleep/wake control.
// Optional macro SRAM_BANK_BRIDGE_RDATA_REG_EN adds one registered response stage.
module sram_bank_bridge
    import sram_bridge_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter int IDLE_CYCLES  = 16,
    parameter int WAKE_CYCLES  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    sram_bank_bridge_if.slave         bus,
    output logic                      sram_csb_o,
    output logic                      sram_web_o,
    output logic [DATA_WIDTH/8-1:0]   sram_wmask_o,
    output logic [ADDR_WIDTH-3:0]     sram_addr_o,
    output logic [DATA_WIDTH-1:0]     sram_din_o,
    input  logic [DATA_WIDTH-1:0]     sram_dout_i,
    output logic                      sram_sleep_o
);
    localparam int WORD_AW = ADDR_WIDTH - 2;
    localparam int IDLE_W  = idle_cnt_width(IDLE_CYCLES);
    localparam bit SLEEP_EN = (IDLE_CYCLES > 0);
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        IDLE_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
    localparam logic [WAKE_CNT_WIDTH-1:0] WAKE_LAST = WAKE_CNT_WIDTH'(WAKE_CYCLES - 1);

    pwr_state_t                  state_q, state_d;
    logic [IDLE_W-1:0]           idle_cnt_q, idle_cnt_d;
    logic [WAKE_CNT_WIDTH-1:0]   wake_cnt_q, wake_cnt_d;
    logic [WORD_AW-1:0]          addr_q, addr_d;
    logic [DATA_WIDTH-1:0]       din_q, din_d;

    logic                        gnt;
    logic                        wr_gnt;
    logic                        bus_idle;
    logic                        pipe_empty;
    logic                        resp_empty;
    resp_token_t                 push_tok;
    resp_token_t                 head_tok;
    logic [DATA_WIDTH-1:0]       head_rdata;
    logic                        unused_addr_lsb;

    assign unused_addr_lsb = ^bus.slave_data_addr_i[1:0];

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ACTIVE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            addr_q     <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end

    assign bus_idle = ~bus.slave_data_req_i & resp_empty;

    // ---------------- next-state logic ----------------
    // A request in the threshold cycle makes bus_idle low, so the grant wins over sleep.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
        case (state_q)
            ACTIVE: begin
                if (SLEEP_EN && bus_idle) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d    = SLEEP;
                        idle_cnt_d = idle_cnt_q;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            SLEEP: begin
                if (bus.slave_data_req_i) begin
                    state_d = WAKE;
                end
            end
            WAKE: begin
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d = ACTIVE;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    // ---------------- output logic ----------------
    // Grant is qualified by reset_n so the macro stays deselected while reset is held.
    always_comb begin
        gnt              = reset_n & bus.slave_data_req_i & (state_q == ACTIVE);
        wr_gnt           = gnt & bus.slave_data_we_i;
        sram_sleep_o     = (state_q == SLEEP) & ~bus.slave_data_req_i;
        sram_csb_o       = ~gnt;
        sram_web_o       = ~wr_gnt;
        sram_wmask_o     = wr_gnt ? bus.slave_data_be_i : '0;
        addr_d           = gnt ? bus.slave_data_addr_i[ADDR_WIDTH-1:2] : addr_q;
        din_d            = gnt ? bus.slave_data_wdata_i : din_q;
        push_tok.valid   = gnt;
        push_tok.is_read = gnt & ~bus.slave_data_we_i;
    end

    assign bus.slave_data_gnt_o = gnt;
    assign sram_addr_o          = addr_d;
    assign sram_din_o           = din_d;

    sram_resp_pipe #(
        .DEPTH   (READ_LATENCY)
    ) u_resp_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_tok),
        .head_o  (head_tok),
        .empty_o (pipe_empty)
    );

    // Writes still return a response, but with zero data rather than whatever dout holds.
    assign head_rdata = (head_tok.valid & head_tok.is_read) ? sram_dout_i : '0;

`ifdef SRAM_BANK_BRIDGE_RDATA_REG_EN
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rvalid_d = head_tok.valid;
        rdata_d  = head_rdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign resp_empty              = pipe_empty & ~rvalid_q;
    assign bus.slave_data_rvalid_o = rvalid_q;
    assign bus.slave_data_rdata_o  = rdata_q;
`else
    assign resp_empty              = pipe_empty;
    assign bus.slave_data_rvalid_o = head_tok.valid;
    assign bus.slave_data_rdata_o  = head_rdata;
`endif

endmodule

// File: tb/tb_sram_bank_bridge.sv
// Directed bench: dut0 has READ_LATENCY=1 with sleep enabled, dut1 has READ_LATENCY=3 and no sleep.
module tb_sram_bank_bridge;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n  [2];
    logic            req    [2];
    logic            we     [2];
    logic [AW-1:0]   addr   [2];
    logic [BW-1:0]   be     [2];
    logic [DW-1:0]   wdata  [2];
    logic            gnt    [2];
    logic            rvalid [2];
    logic [DW-1:0]   rdata  [2];
    logic            csb    [2];
    logic            web    [2];
    logic [BW-1:0]   wmask  [2];
    logic [AW-3:0]   saddr  [2];
    logic [DW-1:0]   din    [2];
    logic            sleep  [2];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int RL   = (gi == 0) ? 1 : 3;
        localparam int IDLE = (gi == 0) ? 16 : 0;

        sram_bank_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
        logic [DW-1:0] dout;
        logic [DW-1:0] mem   [256];
        logic [DW-1:0] dpipe [RL];

        assign bus.slave_data_req_i   = req[gi];
        assign bus.slave_data_addr_i  = addr[gi];
        assign bus.slave_data_we_i    = we[gi];
        assign bus.slave_data_be_i    = be[gi];
        assign bus.slave_data_wdata_i = wdata[gi];
        assign gnt[gi]    = bus.slave_data_gnt_o;
        assign rvalid[gi] = bus.slave_data_rvalid_o;
        assign rdata[gi]  = bus.slave_data_rdata_o;

        sram_bank_bridge #(
            .DATA_WIDTH   (DW),
            .ADDR_WIDTH   (AW),
            .READ_LATENCY (RL),
            .IDLE_CYCLES  (IDLE),
            .WAKE_CYCLES  (2)
        ) u_dut (
            .clk          (clk),
            .reset_n      (rst_n[gi]),
            .bus          (bus),
            .sram_csb_o   (csb[gi]),
            .sram_web_o   (web[gi]),
            .sram_wmask_o (wmask[gi]),
            .sram_addr_o  (saddr[gi]),
            .sram_din_o   (din[gi]),
            .sram_dout_i  (dout),
            .sram_sleep_o (sleep[gi])
        );

        // Behavioural macro: masked write on the select edge, read data RL cycles later.
        assign dout = dpipe[RL-1];
        always @(posedge clk) begin
            if (!csb[gi] && !web[gi]) begin
                for (int b = 0; b < BW; b++) begin
                    if (wmask[gi][b]) mem[saddr[gi]][8*b +: 8] <= din[gi][8*b +: 8];
                end
            end
            dpipe[0] <= (!csb[gi] && web[gi]) ? mem[saddr[gi]] : 32'hBAD0_BAD0;
            for (int k = 1; k < RL; k++) dpipe[k] <= dpipe[k-1];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [BW-1:0] b, input logic [DW-1:0] wd);
        req[d] = r; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
        if (r) $display("[TB] dut%0d %s addr=0x%03h be=0x%h wdata=0x%08h", d, w ? "WR" : "RD", a, b, wd);
    endtask

    task automatic check_reset_outputs(input int d, input string tag);
        check({tag, "_gnt"},    gnt[d],    32'd0);
        check({tag, "_rvalid"}, rvalid[d], 32'd0);
        check({tag, "_rdata"},  rdata[d],  32'd0);
        check({tag, "_csb"},    csb[d],    32'd1);
        check({tag, "_web"},    web[d],    32'd1);
        check({tag, "_wmask"},  wmask[d],  32'd0);
        check({tag, "_addr"},   saddr[d],  32'd0);
        check({tag, "_din"},    din[d],    32'd0);
        check({tag, "_sleep"},  sleep[d],  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        logic saw_sleep;

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            drive(d, 1'b0, 1'b0, '0, '0, '0);
        end
        req[0] = 1'b1;   // request during reset must not be granted
        step(); #2;
        check_reset_outputs(0, "rst0");
        req[0] = 1'b0;
        step();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // ---- dut0: write then read, READ_LATENCY=1 ----
        drive(0, 1, 1, 10'h010, 4'hF, 32'hDEADBEEF); #2;
        check("wr_gnt", gnt[0], 1); check("wr_csb", csb[0], 0); check("wr_web", web[0], 0);
        check("wr_wmask", wmask[0], 4'hF); check("wr_addr", saddr[0], 8'h04);
        check("wr_din", din[0], 32'hDEADBEEF); check("wr_rvalid_early", rvalid[0], 0);
        step();
        drive(0, 1, 0, 10'h010, 4'h0, 32'h0BADF00D); #2;
        check("rd_gnt", gnt[0], 1); check("rd_web", web[0], 1); check("rd_wmask", wmask[0], 0);
        check("wr_resp_rvalid", rvalid[0], 1); check("wr_resp_rdata", rdata[0], 0);
        step();
        drive(0, 0, 0, 10'h3FC, 4'h0, 32'h0); #2;
        check("rd_resp_rvalid", rvalid[0], 1); check("rd_resp_rdata", rdata[0], 32'hDEADBEEF);
        check("idle_csb", csb[0], 1); check("idle_web", web[0], 1);
        check("hold_addr", saddr[0], 8'h04); check("hold_din", din[0], 32'h0BADF00D);
        step();

        // ---- dut0: partial write and zero-mask write ----
        drive(0, 1, 1, 10'h020, 4'hF, 32'h11223344); #2;
        check("idle_rvalid", rvalid[0], 0); check("idle_rdata", rdata[0], 0);
        step();
        drive(0, 1, 1, 10'h021, 4'h2, 32'h0000AB00); #2;
        check("pw_wmask", wmask[0], 4'h2); check("pw_addr_lsb_ignored", saddr[0], 8'h08);
        step();
        drive(0, 1, 0, 10'h020, 4'h0, 32'h0);
        step();
        drive(0, 0, 0, 10'h0, 4'h0, 32'h0); #2;
        check("pw_rvalid", rvalid[0], 1); check("pw_rdata", rdata[0], 32'h1122AB44);
        step();
        drive(0, 1, 1, 10'h020, 4'h0, 32'hFFFFFFFF); #2;
        check("be0_gnt", gnt[0], 1); check("be0_csb", csb[0], 0); check("be0_web", web[0], 0);
        check("be0_wmask", wmask[0], 0);
        step();
        drive(0, 1, 0, 10'h020, 4'h0, 32'h0); #2;
        check("be0_rvalid", rvalid[0], 1); check("be0_rdata", rdata[0], 0);
        step();
        drive(0, 0, 0, 10'h0, 4'h0, 32'h0); #2;
        check("be0_read_rdata", rdata[0], 32'h1122AB44);
        step(); #2;

        // ---- dut0: idle into sleep, then wake on request ----
        n = 0;
        while (!sleep[0] && n < 40) begin
            n++;
            step(); #2;
        end
        check("idle_cycles_to_sleep", n, 16);
        check("sleep_high", sleep[0], 1); check("sleep_no_gnt", gnt[0], 0);
        step();
        drive(0, 1, 0, 10'h010, 4'h0, 32'h0); #2;
        check("wake_req_sleep_low", sleep[0], 0); check("wake_req_gnt_low", gnt[0], 0);
        n = 0;
        saw_sleep = 1'b0;
        while (!gnt[0] && n < 10) begin
            n++;
            step(); #2;
            saw_sleep = saw_sleep | sleep[0];
        end
        check("wake_penalty", n, 3); check("wake_sleep_stays_low", saw_sleep, 0);
        check("wake_csb", csb[0], 0); check("wake_addr", saddr[0], 8'h04);
        step();
        drive(0, 0, 0, 10'h0, 4'h0, 32'h0); #2;
        check("wake_rvalid", rvalid[0], 1); check("wake_rdata", rdata[0], 32'hDEADBEEF);

        // ---- dut0: request lands in the threshold cycle ----
        repeat (16) step();
        drive(0, 1, 1, 10'h030, 4'hF, 32'h55AA55AA); #2;
        check("thr_gnt", gnt[0], 1); check("thr_sleep", sleep[0], 0);
        step();
        drive(0, 0, 0, 10'h0, 4'h0, 32'h0); #2;
        check("thr_rvalid", rvalid[0], 1); check("thr_no_sleep", sleep[0], 0);
        step(); #2;
        n = 0;
        while (!sleep[0] && n < 40) begin
            n++;
            step(); #2;
        end
        check("thr_counter_restart", n, 16);
        step();

        // ---- dut1: four writes then four back-to-back reads, READ_LATENCY=3 ----
        for (int k = 0; k < 12; k++) begin
            if (k < 4)      drive(1, 1, 1, 10'(12'h100 + 4*k), 4'hF, 32'hA0000001 + 32'(k));
            else if (k < 8) drive(1, 1, 0, 10'(12'h100 + 4*(k-4)), 4'h0, 32'h0);
            else            drive(1, 0, 0, 10'h0, 4'h0, 32'h0);
            #2;
            check($sformatf("burst_gnt_c%0d", k), gnt[1], (k < 8) ? 1 : 0);
            check($sformatf("burst_rvalid_c%0d", k), rvalid[1], (k >= 3 && k <= 10) ? 1 : 0);
            check($sformatf("burst_rdata_c%0d", k), rdata[1],
                  (k >= 7 && k <= 10) ? 32'hA0000001 + 32'(k - 7) : 32'h0);
            step();
        end
        check("rl3_sleep_disabled", sleep[1], 0);

        // ---- dut1: reset with two reads in flight ----
        drive(1, 1, 0, 10'h100, 4'h0, 32'h5A5A5A5A);
        step();
        drive(1, 1, 0, 10'h104, 4'h0, 32'h5A5A5A5A);
        step();
        drive(1, 0, 0, 10'h0, 4'h0, 32'h0);
        step(); #2;
        check("pre_rst_rvalid", rvalid[1], 1); check("pre_rst_rdata", rdata[1], 32'hA0000001);
        rst_n[1] = 1'b0;
        #1;
        check_reset_outputs(1, "async_rst1");
        step();
        rst_n[1] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            if (rvalid[1]) cnt++;
            step();
        end
        check("no_rvalid_after_reset", cnt, 0);
        drive(1, 1, 0, 10'h108, 4'h0, 32'h0); #2;
        check("post_rst_gnt", gnt[1], 1);
        step();
        drive(1, 0, 0, 10'h0, 4'h0, 32'h0); #2;
        n = 1;
        while (!rvalid[1] && n < 10) begin
            step(); #2;
            n++;
        end
        check("post_rst_latency", n, 3); check("post_rst_rdata", rdata[1], 32'hA0000003);
        step(); #2;
        check("post_rst_single_resp", rvalid[1], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_bank_bridge.md
Name: sram_bank_bridge

Overview:
Sits directly downstream of the crossbar interconnect, one instance per slave port. It converts the interconnect's slave-side req/gnt/rvalid protocol into a single-port SRAM macro interface: active-low chip select, active-low write enable, byte write mask, and a fixed read latency. It produces in-order responses and contains an idle-driven sleep/wake FSM for macro power-down.

Parameters:
- DATA_WIDTH, 32: data width; must be a multiple of 8.
- ADDR_WIDTH, 10: byte address width, matching the interconnect slave address width.
- READ_LATENCY, 1: macro cycles from the csb-low edge to valid dout; legal range 1..4.
- IDLE_CYCLES, 16: consecutive idle cycles before sleep entry; 0 disables sleep.
- WAKE_CYCLES, 2: cycles from sleep deassertion until the macro is usable; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- slave_data_req_i  in  1  request from the interconnect.
- slave_data_addr_i  in  ADDR_WIDTH  byte address.
- slave_data_we_i  in  1  1 = write.
- slave_data_be_i  in  DATA_WIDTH/8  byte enables.
- slave_data_wdata_i  in  DATA_WIDTH  write data.
- slave_data_gnt_o  out  1  request accepted this cycle.
- slave_data_rvalid_o  out  1  response valid.
- slave_data_rdata_o  out  DATA_WIDTH  read data.
- sram_csb_o  out  1  chip select, active low.
- sram_web_o  out  1  write enable, active low.
- sram_wmask_o  out  DATA_WIDTH/8  byte write mask.
- sram_addr_o  out  ADDR_WIDTH-2  word address.
- sram_din_o  out  DATA_WIDTH  macro write data.
- sram_dout_i  in  DATA_WIDTH  macro read data.
- sram_sleep_o  out  1  macro sleep/power-down.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - gnt=0, rvalid=0, rdata=0.
  - csb=1, web=1, wmask=0, addr=0, din=0.
  - sleep_o=0.
  - FSM=ACTIVE, idle counter=0, response pipeline cleared.
- Reset mid-operation: all in-flight responses are dropped. No rvalid is issued for them after release.
- gnt is combinational: gnt = req_i & (state==ACTIVE).
- When gnt is high in a cycle, the macro signals are driven combinationally in that same cycle:
  - csb=0.
  - web = ~we_i.
  - wmask = we_i ? be_i : 0.
  - addr = addr_i[ADDR_WIDTH-1:2]; the low two address bits are ignored.
  - din = wdata_i.
- When gnt is low: csb=1, web=1, wmask=0; addr and din hold their last values.
- Response pipeline:
  - Each grant pushes a token {valid, is_read} into a READ_LATENCY-deep shift register.
  - rvalid=1 exactly READ_LATENCY cycles after the grant cycle.
  - Reads: rdata = sram_dout_i in the rvalid cycle.
  - Writes also receive rvalid, with rdata=0.
  - rdata=0 whenever rvalid=0.
- Throughput and ordering: back-to-back grants every cycle; responses stay in order. There is no response backpressure.
- Write with be=0: granted, csb=0, wmask=0; memory is unchanged and rvalid still follows.
- FSM states: ACTIVE, SLEEP, WAKE.
  - ACTIVE: the idle counter increments while req=0 and the pipeline is empty, and clears on any req or in-flight token. When the counter reaches IDLE_CYCLES-1 with req=0 and an empty pipeline, the FSM moves to SLEEP. If req=1 in that same cycle, the request wins: stay ACTIVE and grant.
  - SLEEP: sleep_o=1, gnt=0. On req=1, deassert sleep_o and move to WAKE. The request is held pending; the interconnect keeps req high.
  - WAKE: sleep_o=0, gnt=0. A counter runs for WAKE_CYCLES; then the FSM returns to ACTIVE and the pending req is granted in the first ACTIVE cycle.
- Worst-case wake penalty: WAKE_CYCLES+1 cycles from req to gnt.
- IDLE_CYCLES=0: the FSM never leaves ACTIVE.
- Counter widths: $clog2(IDLE_CYCLES+1) for the idle counter, 4 bits for the wake counter. Neither counter wraps; each saturates at its threshold.

Optional Feature:
- Macro: SRAM_BANK_BRIDGE_RDATA_REG_EN.
- Defined: rvalid and rdata are registered one extra stage, giving READ_LATENCY+1 total latency. Sleep entry additionally requires this stage to be empty.
- Undefined: latency is exactly READ_LATENCY and rdata is driven combinationally from sram_dout_i.

Decomposition:
- Package sram_bridge_pkg:
  - pwr_state_t enum {ACTIVE, SLEEP, WAKE}.
  - MAX_READ_LATENCY=4.
  - MAX_WAKE_CYCLES=15.
  - resp_token_t struct {valid, is_read}.
- Sub-module sram_resp_pipe: parameterised token shift register. It exposes head token and empty flag, with a flush on reset.

Test Plan:
- Write addr=0x010, be=0xF, wdata=0xDEADBEEF, then read 0x010 (READ_LATENCY=1) -> write cycle drives csb=0, web=0, wmask=0xF, sram_addr=0x04; read rvalid arrives 1 cycle after its gnt with rdata=0xDEADBEEF; the write's rvalid has rdata=0.
- Four back-to-back reads with READ_LATENCY=3 -> gnt held high 4 cycles; rvalid high 4 cycles starting 3 cycles after the first gnt; data returned in address order.
- Partial write be=0x2 of 0x0000AB00 over 0x11223344, then read -> wmask=0x2; readback 0x1122AB44.
- Idle 16 cycles (IDLE_CYCLES=16) -> sleep_o rises; a req then keeps gnt low for WAKE_CYCLES=2 and asserts gnt on the 3rd cycle, with sleep_o=0 from the req cycle onward.
- req arrives exactly in the threshold cycle -> no SLEEP entry, gnt=1 that cycle, idle counter=0 the next cycle.
- Pull reset_n low with 2 reads in flight (READ_LATENCY=3) -> all outputs at reset values asynchronously; no rvalid after release; the first new read responds normally.
